// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the SRAM slave: transfer types, sizes, response codes and error FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BYTE = 3'd0,
        HALF = 3'd1,
        WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_e;

endpackage

// File: rtl/ahb_sram_be_dec.sv
// Byte-lane enable decoder: transfer size plus low address bits -> 4-bit lane strobe (little-endian lanes).
module ahb_sram_be_dec
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr,
    output logic [3:0] be
);

    // Sub-word sizes align down; anything at or above word size writes all lanes.
    always_comb begin
        be = 4'b1111;
        case (size)
            BYTE: be = 4'b0001 << addr;
            HALF: begin
                if (addr[1]) begin
                    be = 4'b1100;
                end else begin
                    be = 4'b0011;
                end
            end
            default: be = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram.sv
// AHB-Lite zero-wait-state SRAM slave. Define AHB_SRAM_RANGE_CHECK_EN to answer out-of-range
// transfers with a two-cycle ERROR; otherwise offsets wrap modulo MEMSIZE.
module ahb_lite_sram
    import ahb_pkg::*;
#(
    parameter int MEMSIZE = 524288,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          hclk,
    input  logic          hreset_n,
    input  logic          hsel,
    input  logic [AW-1:0] base_addr,
    input  logic [1:0]    htrans,
    input  logic [AW-1:0] haddr,
    input  logic [2:0]    hsize,
    input  logic [DW-1:0] hwdata,
    input  logic          hwrite,
    input  logic          hready_in,
    output logic [DW-1:0] hrdata,
    output logic          hresp,
    output logic          hready_out
);

    localparam int WORDS = MEMSIZE / 4;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [DW-1:0] mem [0:WORDS-1];

    logic [AW-1:0] offset_s;
    logic [IW-1:0] idx_s;
    logic          xfer_s;
    logic          accept_s;
    logic [3:0]    be_s;

    logic          valid_r;
    logic          write_r;
    logic [2:0]    size_r;
    logic [1:0]    lane_r;
    logic [IW-1:0] idx_r;

    assign xfer_s   = hsel & hready_in & ((htrans == NONSEQ) | (htrans == SEQ));
    assign offset_s = haddr - base_addr;
    assign idx_s    = IW'((offset_s >> 2) & AW'(WORDS - 1));

`ifdef AHB_SRAM_RANGE_CHECK_EN
    localparam logic [AW-1:0] MEM_BYTES = AW'(MEMSIZE);

    err_state_e state_r;
    logic       hready_r;
    logic       hresp_r;
    logic       range_err_s;

    // A negative offset wraps to a huge unsigned value, so one compare covers both ends.
    assign range_err_s = (offset_s >= MEM_BYTES);
    assign accept_s    = xfer_s & (state_r == ST_IDLE) & ~range_err_s;

    // Error response FSM: low-ready ERROR cycle, then high-ready ERROR cycle, transfers ignored meanwhile.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_r  <= ST_IDLE;
            hready_r <= 1'b1;
            hresp_r  <= HRESP_OKAY;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s && range_err_s) begin
                        state_r  <= ST_ERR1;
                        hready_r <= 1'b0;
                        hresp_r  <= HRESP_ERROR;
                    end else begin
                        state_r  <= ST_IDLE;
                        hready_r <= 1'b1;
                        hresp_r  <= HRESP_OKAY;
                    end
                end
                ST_ERR1: begin
                    state_r  <= ST_ERR2;
                    hready_r <= 1'b1;
                    hresp_r  <= HRESP_ERROR;
                end
                ST_ERR2: begin
                    state_r  <= ST_IDLE;
                    hready_r <= 1'b1;
                    hresp_r  <= HRESP_OKAY;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    hready_r <= 1'b1;
                    hresp_r  <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign hready_out = hready_r;
    assign hresp      = hresp_r;
`else
    assign accept_s   = xfer_s;
    assign hready_out = 1'b1;
    assign hresp      = HRESP_OKAY;
`endif

    // Data-phase registers captured from the address phase.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            valid_r <= 1'b0;
            write_r <= 1'b0;
            size_r  <= 3'd0;
            lane_r  <= 2'd0;
            idx_r   <= '0;
        end else if (accept_s) begin
            valid_r <= 1'b1;
            write_r <= hwrite;
            size_r  <= hsize;
            lane_r  <= haddr[1:0];
            idx_r   <= idx_s;
        end else begin
            valid_r <= 1'b0;
        end
    end

    ahb_sram_be_dec u_be_dec (
        .size (size_r),
        .addr (lane_r),
        .be   (be_s)
    );

    // Write commits at the edge closing the data phase, so a following read sees the new data.
    always_ff @(posedge hclk) begin
        if (valid_r && write_r) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem[idx_r][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Read data is driven straight from the array during a read data phase.
    always_comb begin
        if (valid_r && !write_r) begin
            hrdata = mem[idx_r];
        end else begin
            hrdata = '0;
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram.sv
// Directed self-checking bench for ahb_lite_sram; expected values are hand-computed constants.
module tb_ahb_lite_sram;
    import ahb_pkg::*;

    logic        hclk;
    logic        hreset_n;
    logic        hsel;
    logic [31:0] base_addr;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hwrite;
    logic        hready_in;
    logic [31:0] hrdata;
    logic        hresp;
    logic        hready_out;

    int checks;
    int failures;

    ahb_lite_sram dut (
        .hclk       (hclk),
        .hreset_n   (hreset_n),
        .hsel       (hsel),
        .base_addr  (base_addr),
        .htrans     (htrans),
        .haddr      (haddr),
        .hsize      (hsize),
        .hwdata     (hwdata),
        .hwrite     (hwrite),
        .hready_in  (hready_in),
        .hrdata     (hrdata),
        .hresp      (hresp),
        .hready_out (hready_out)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_ph(input logic s, input logic [1:0] t, input logic [31:0] a,
                           input logic [2:0] sz, input logic w);
        hsel   = s;
        htrans = t;
        haddr  = a;
        hsize  = sz;
        hwrite = w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        hreset_n  = 1'b0;
        base_addr = 32'h4000_0000;
        hready_in = 1'b1;
        hwdata    = 32'h0;
        addr_ph(1'b0, IDLE, 32'h0, WORD, 1'b0);
        step();
        step();
        check("rst_hready", {31'd0, hready_out}, 32'd1);
        check("rst_hresp",  {31'd0, hresp},      32'd0);
        check("rst_hrdata", hrdata,              32'h0);
        hreset_n = 1'b1;
        step();

        // word write then back-to-back read of the same address
        addr_ph(1'b1, NONSEQ, 32'h4000_0000, WORD, 1'b1);
        step();
        hwdata = 32'hDEAD_BEEF;
        check("wr_dphase_hrdata", hrdata, 32'h0);
        addr_ph(1'b1, NONSEQ, 32'h4000_0000, WORD, 1'b0);
        step();
        check("b2b_read", hrdata, 32'hDEAD_BEEF);
        check("b2b_hresp", {31'd0, hresp}, 32'd0);
        check("b2b_hready", {31'd0, hready_out}, 32'd1);
        addr_ph(1'b0, IDLE, 32'h0, WORD, 1'b0);
        step();
        check("idle_hrdata", hrdata, 32'h0);

        // word, byte lane 1, half lanes 3:2
        addr_ph(1'b1, NONSEQ, 32'h4000_0000, WORD, 1'b1);
        step();
        hwdata = 32'h1122_3344;
        addr_ph(1'b1, NONSEQ, 32'h4000_0001, BYTE, 1'b1);
        step();
        hwdata = 32'h0000_5500;
        addr_ph(1'b1, SEQ, 32'h4000_0000, WORD, 1'b0);
        step();
        check("byte_write", hrdata, 32'h1122_5544);
        addr_ph(1'b1, NONSEQ, 32'h4000_0002, HALF, 1'b1);
        step();
        hwdata = 32'hAABB_0000;
        addr_ph(1'b1, NONSEQ, 32'h4000_0000, WORD, 1'b0);
        step();
        check("half_write", hrdata, 32'hAABB_5544);

        // backdoor load, then IDLE/BUSY writes must not touch the array
        dut.mem[2] = 32'h0000_0113;
        addr_ph(1'b1, NONSEQ, 32'h4000_0008, WORD, 1'b0);
        step();
        check("backdoor_read", hrdata, 32'h0000_0113);
        addr_ph(1'b1, BUSY, 32'h4000_0008, WORD, 1'b1);
        step();
        hwdata = 32'hFFFF_FFFF;
        check("busy_hrdata", hrdata, 32'h0);
        check("busy_hresp", {31'd0, hresp}, 32'd0);
        addr_ph(1'b1, IDLE, 32'h4000_0008, WORD, 1'b1);
        step();
        check("idle_hresp", {31'd0, hresp}, 32'd0);

        // hsel low, then hready_in low, with NONSEQ writes
        addr_ph(1'b0, NONSEQ, 32'h4000_0008, WORD, 1'b1);
        step();
        hready_in = 1'b0;
        addr_ph(1'b1, NONSEQ, 32'h4000_0008, WORD, 1'b1);
        step();
        hready_in = 1'b1;
        addr_ph(1'b1, NONSEQ, 32'h4000_0008, WORD, 1'b0);
        step();
        hwdata = 32'h0;
        check("no_access_mem", hrdata, 32'h0000_0113);

        // unaligned half write aligns down to lanes 3:2; unaligned word read aligns down
        addr_ph(1'b1, NONSEQ, 32'h4000_0003, HALF, 1'b1);
        step();
        hwdata = 32'h1234_0000;
        addr_ph(1'b1, NONSEQ, 32'h4000_0003, WORD, 1'b0);
        step();
        check("unaligned", hrdata, 32'h1234_5544);

        // out-of-range read
        addr_ph(1'b1, NONSEQ, 32'h4008_0000, WORD, 1'b0);
        step();
        addr_ph(1'b0, IDLE, 32'h0, WORD, 1'b0);
`ifdef AHB_SRAM_RANGE_CHECK_EN
        check("err1_hready", {31'd0, hready_out}, 32'd0);
        check("err1_hresp",  {31'd0, hresp},      32'd1);
        check("err1_hrdata", hrdata,              32'h0);
        step();
        check("err2_hready", {31'd0, hready_out}, 32'd1);
        check("err2_hresp",  {31'd0, hresp},      32'd1);
        step();
        check("err_done_hresp", {31'd0, hresp}, 32'd0);
`else
        check("wrap_read",  hrdata,              32'h1234_5544);
        check("wrap_hresp", {31'd0, hresp},      32'd0);
        step();
`endif

        // reset during a write data phase discards the write
        dut.mem[3] = 32'h0000_0000;
        addr_ph(1'b1, NONSEQ, 32'h4000_000C, WORD, 1'b1);
        step();
        hwdata = 32'h9999_9999;
        addr_ph(1'b0, IDLE, 32'h0, WORD, 1'b0);
        #1;
        hreset_n = 1'b0;
        step();
        check("midrst_hrdata", hrdata, 32'h0);
        hreset_n = 1'b1;
        addr_ph(1'b1, NONSEQ, 32'h4000_000C, WORD, 1'b0);
        step();
        check("midrst_discard", hrdata, 32'h0);
        addr_ph(1'b0, IDLE, 32'h0, WORD, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
